stopwatch_button_ctrl: RTL and testbench
========================================

STOPWATCH_BUTTON_CTRL -- requirements
Module: stopwatch_button_ctrl

Interface
REQ-001 Parameter N_BTN, default 2, number of button channels; legal values are N_BTN >= 2; ch0 = start/stop, ch1 = lap/reset, higher channels produce events only.
REQ-002 Parameter DBNC_DIV, default 500_000, clk cycles per debounce tick.
REQ-003 Parameter LONG_TICKS, default 200, debounce ticks a press is held before it counts as long.
REQ-004 clk  input  1  the single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 button  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-007 short_evt  output  N_BTN  per-channel 1-cycle pulse, short press released.
REQ-008 long_evt  output  N_BTN  per-channel 1-cycle pulse, hold reached LONG_TICKS.
REQ-009 clear  output  1  high while the FSM is in CLEAR.
REQ-010 prepare_start  output  1  1-cycle pulse on every transition into RUN from IDLE or STOP.
REQ-011 running  output  1  high in RUN and LAP.
REQ-012 lap_freeze  output  1  high in LAP; the display holds its value while time keeps counting.

Function
REQ-013 A shared prescaler SHALL count 0..DBNC_DIV-1 and SHALL emit a 1-cycle tick on wrap.
REQ-014 Each button SHALL pass through a 2-FF synchronizer before any other logic uses it.
REQ-015 On each tick, each channel SHALL sample the synced level; the debounced level SHALL take that sample only when it equals the previous tick's sample.
REQ-016 On a debounced 0->1 transition, the hold counter SHALL clear; it SHALL increment on each tick while the channel is pressed and saturate at LONG_TICKS.
REQ-017 When the hold counter reaches LONG_TICKS, the channel SHALL pulse long_evt exactly once per press.
REQ-018 On a debounced 1->0 transition with hold < LONG_TICKS, the channel SHALL pulse short_evt; a release after a long press SHALL produce no event.
REQ-019 FSM states: CLEAR, IDLE, RUN, LAP, STOP.
REQ-020 CLEAR -> IDLE after exactly one cycle.
REQ-021 IDLE: ch0 short -> RUN.
REQ-022 RUN: ch0 short -> STOP; ch1 short -> LAP.
REQ-023 LAP: ch1 short -> RUN; ch0 short -> STOP.
REQ-024 STOP: ch0 short -> RUN; ch1 short -> CLEAR.
REQ-025 ch0 long_evt SHALL force CLEAR from any state, overriding every other event in that cycle.
REQ-026 Simultaneous ch0 and ch1 short events: ch0 SHALL win and the ch1 event SHALL be dropped.
REQ-027 Events not listed for a state SHALL be ignored; channels >= 2 SHALL never affect the FSM.
REQ-028 FSM outputs SHALL be Moore-decoded from the registered state, except prepare_start, which SHALL be registered alongside the transition.
REQ-029 Latency: a button edge that is stable across the debounce SHALL reach the FSM within 2 + 2*DBNC_DIV + 2 cycles.

Reset
REQ-030 rst SHALL set: FSM to CLEAR, prescaler 0, synchronizers 0, debounced levels 0, hold counters 0, all event outputs 0, prepare_start 0.
REQ-031 clear SHALL read 1 during rst and for the first cycle after rst deasserts; running, lap_freeze, short_evt and long_evt SHALL read 0.
REQ-032 A button held through rst SHALL be detected afterwards as a new press via normal debounce; no release event SHALL be generated for the pre-reset press.

Structure
REQ-033 The state encoding localparams and a clog2-based width helper SHALL live in the shared package stopwatch_pkg.
REQ-034 The per-channel synchronizer, debounce, hold counter and event logic SHALL be sub-module btn_event, instantiated N_BTN times by a generate loop; the prescaler and FSM SHALL stay in the top module.
REQ-035 Counter widths SHALL be clog2(DBNC_DIV) and clog2(LONG_TICKS+1).

Verification (N_BTN=3, DBNC_DIV=4, LONG_TICKS=8)
REQ-036 ch0 held for 3 ticks, then released -> one short_evt[0]; IDLE->RUN; prepare_start high for 1 cycle; running=1.
REQ-037 In RUN, ch1 short -> LAP (lap_freeze=1, running=1); ch1 short again -> RUN with lap_freeze=0.
REQ-038 ch0 held for 12 ticks in RUN -> long_evt[0] exactly once at tick 8; clear=1 for 1 cycle, then IDLE; release gives no short_evt.
REQ-039 In STOP, ch0 and ch1 short events in the same cycle -> RUN, prepare_start pulses, no CLEAR.
REQ-040 ch0 toggling every 2 clk cycles (faster than a tick) -> no events and no state change; short_evt[2] never moves the FSM.
REQ-041 rst asserted mid-press while in RUN, button held throughout -> after rst: clear=1 for 1 cycle, then IDLE; a short_evt[0] appears only after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button controller: FSM state encoding
// and the counter-width helper used by the top and the per-button logic.
package stopwatch_pkg;

  localparam logic [2:0] STATE_CLEAR = 3'd0;
  localparam logic [2:0] STATE_IDLE  = 3'd1;
  localparam logic [2:0] STATE_RUN   = 3'd2;
  localparam logic [2:0] STATE_LAP   = 3'd3;
  localparam logic [2:0] STATE_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_CLEAR = STATE_CLEAR,
    ST_IDLE  = STATE_IDLE,
    ST_RUN   = STATE_RUN,
    ST_LAP   = STATE_LAP,
    ST_STOP  = STATE_STOP
  } state_e;

  // Bits needed for a counter with n distinct values, never narrower than 1.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event.sv
// One button channel: 2-FF synchronizer, tick-sampled debounce, hold counter
// and short/long press event generation.
module btn_event
  import stopwatch_pkg::*;
#(
  parameter int LONG_TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button,
  output logic short_evt,
  output logic long_evt
);

  localparam int HOLD_W = cnt_width(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              sample_q, sample_d;
  logic              level_q, level_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              short_q, short_d;
  logic              long_q, long_d;

  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    sample_d = sample_q;
    level_d  = level_q;
    hold_d   = hold_q;
    short_d  = 1'b0;
    long_d   = 1'b0;

    if (tick) begin
      sample_d = sync2_q;
      // The level only follows two consecutive agreeing tick samples.
      if (sync2_q == sample_q) begin
        level_d = sync2_q;
      end

      if (!level_q && level_d) begin
        hold_d = '0;
      end else if (level_q && level_d) begin
        if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
          long_d = (hold_d == HOLD_MAX);
        end
      end else if (level_q && !level_d) begin
        short_d = (hold_q < HOLD_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      level_q  <= 1'b0;
      hold_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      short_q  <= short_d;
      long_q   <= long_d;
    end
  end

  assign short_evt = short_q;
  assign long_evt  = long_q;

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch front panel: shared debounce prescaler, one btn_event per button
// and the CLEAR/IDLE/RUN/LAP/STOP control FSM driven by ch0/ch1 events.
module stopwatch_button_ctrl
  import stopwatch_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int DBNC_DIV   = 500_000,
  parameter int LONG_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] short_evt,
  output logic [N_BTN-1:0] long_evt,
  output logic             clear,
  output logic             prepare_start,
  output logic             running,
  output logic             lap_freeze
);

  localparam int PRE_W = cnt_width(DBNC_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DBNC_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  state_e           state_q, state_d;
  logic             prepare_q, prepare_d;

  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_event #(
      .LONG_TICKS(LONG_TICKS)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .button   (button[g]),
      .short_evt(short_evt[g]),
      .long_evt (long_evt[g])
    );
  end

  // ch0 is checked before ch1 in every state so a simultaneous ch1 event is dropped.
  always_comb begin
    state_d = state_q;
    if (long_evt[0]) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = ST_IDLE;
        ST_IDLE: begin
          if (short_evt[0]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (short_evt[0])      state_d = ST_STOP;
          else if (short_evt[1]) state_d = ST_LAP;
        end
        ST_LAP: begin
          if (short_evt[0])      state_d = ST_STOP;
          else if (short_evt[1]) state_d = ST_RUN;
        end
        ST_STOP: begin
          if (short_evt[0])      state_d = ST_RUN;
          else if (short_evt[1]) state_d = ST_CLEAR;
        end
        default: state_d = ST_CLEAR;
      endcase
    end
    prepare_d = (state_d == ST_RUN) && ((state_q == ST_IDLE) || (state_q == ST_STOP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      state_q   <= ST_CLEAR;
      prepare_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      state_q   <= state_d;
      prepare_q <= prepare_d;
    end
  end

  always_comb begin
    clear         = (state_q == ST_CLEAR);
    running       = (state_q == ST_RUN) || (state_q == ST_LAP);
    lap_freeze    = (state_q == ST_LAP);
    prepare_start = prepare_q;
  end

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Scoreboard bench for stopwatch_button_ctrl: expected event vectors are queued
// as buttons are driven and matched against every nonzero event/prepare cycle.
module tb_stopwatch_button_ctrl;

  localparam int N_BTN = 3;
  localparam int DIV   = 4;
  localparam int LT    = 8;

  // Scoreboard entry layout: {short_evt[2:0], long_evt[2:0], prepare_start}
  localparam logic [6:0] EV_SHORT0  = 7'b0010000;
  localparam logic [6:0] EV_SHORT1  = 7'b0100000;
  localparam logic [6:0] EV_SHORT2  = 7'b1000000;
  localparam logic [6:0] EV_SHORT01 = 7'b0110000;
  localparam logic [6:0] EV_LONG0   = 7'b0000010;
  localparam logic [6:0] EV_PREP    = 7'b0000001;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] button;
  logic [N_BTN-1:0] short_evt;
  logic [N_BTN-1:0] long_evt;
  logic             clear;
  logic             prepare_start;
  logic             running;
  logic             lap_freeze;

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         clearCycles = 0;
  int         longSeen;
  logic [6:0] expQ[$];
  logic [6:0] obs;
  logic [7:0] bouncePat;

  stopwatch_button_ctrl #(
    .N_BTN     (N_BTN),
    .DBNC_DIV  (DIV),
    .LONG_TICKS(LT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .short_evt    (short_evt),
    .long_evt     (long_evt),
    .clear        (clear),
    .prepare_start(prepare_start),
    .running      (running),
    .lap_freeze   (lap_freeze)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Press the masked buttons for the given number of ticks, release, let it settle.
  task automatic applyStimulus(input logic [N_BTN-1:0] mask, input int holdTicks);
    button = mask;
    waitCycles(holdTicks * DIV);
    button = '0;
    waitCycles(8 * DIV);
  endtask

  always @(negedge clk) begin
    obs = {short_evt, long_evt, prepare_start};
    if (clear) clearCycles++;
    if (obs != '0) begin
      if (expQ.size() == 0) checkOutput("unexpected_evt", 32'(obs), 32'd0);
      else                  checkOutput("evt", 32'(obs), 32'(expQ.pop_front()));
    end
  end

  initial begin
    rst    = 1'b1;
    button = '0;
    waitCycles(3);
    checkOutput("rst_clear", 32'(clear), 32'd1);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_lap", 32'(lap_freeze), 32'd0);
    checkOutput("rst_short", 32'(short_evt), 32'd0);
    checkOutput("rst_long", 32'(long_evt), 32'd0);
    checkOutput("rst_prep", 32'(prepare_start), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("clear_after_rst", 32'(clear), 32'd1);
    waitCycles(1);
    checkOutput("idle_clear", 32'(clear), 32'd0);
    checkOutput("idle_running", 32'(running), 32'd0);

    // IDLE -> RUN on a short ch0 press
    expQ.push_back(EV_SHORT0);
    expQ.push_back(EV_PREP);
    applyStimulus(3'b001, 3);
    checkOutput("run_running", 32'(running), 32'd1);
    checkOutput("run_lap", 32'(lap_freeze), 32'd0);

    expQ.push_back(EV_SHORT1);
    applyStimulus(3'b010, 3);
    checkOutput("lap_freeze", 32'(lap_freeze), 32'd1);
    checkOutput("lap_running", 32'(running), 32'd1);
    expQ.push_back(EV_SHORT1);
    applyStimulus(3'b010, 3);
    checkOutput("unlap_freeze", 32'(lap_freeze), 32'd0);
    checkOutput("unlap_running", 32'(running), 32'd1);

    // Long ch0 hold in RUN forces CLEAR, then IDLE; release is silent
    clearCycles = 0;
    longSeen    = 0;
    expQ.push_back(EV_LONG0);
    button = 3'b001;
    for (int i = 0; i < 12 * DIV; i++) begin
      waitCycles(1);
      if (long_evt[0]) longSeen++;
    end
    button = '0;
    waitCycles(8 * DIV);
    checkOutput("long_once", 32'(longSeen), 32'd1);
    checkOutput("long_clear_width", 32'(clearCycles), 32'd1);
    checkOutput("long_idle_running", 32'(running), 32'd0);
    checkOutput("long_idle_clear", 32'(clear), 32'd0);

    // Reach STOP, then press ch0 and ch1 together
    expQ.push_back(EV_SHORT0);
    expQ.push_back(EV_PREP);
    applyStimulus(3'b001, 3);
    expQ.push_back(EV_SHORT0);
    applyStimulus(3'b001, 3);
    checkOutput("stop_running", 32'(running), 32'd0);
    checkOutput("stop_clear", 32'(clear), 32'd0);
    clearCycles = 0;
    expQ.push_back(EV_SHORT01);
    expQ.push_back(EV_PREP);
    applyStimulus(3'b011, 3);
    checkOutput("both_running", 32'(running), 32'd1);
    checkOutput("both_no_clear", 32'(clearCycles), 32'd0);

    // Bounce whose level differs between any two samples one tick apart
    bouncePat = 8'b00101101;
    for (int i = 0; i < 10 * DIV; i++) begin
      button[0] = bouncePat[i % 8];
      waitCycles(1);
    end
    button = '0;
    waitCycles(8 * DIV);
    checkOutput("bounce_running", 32'(running), 32'd1);
    checkOutput("bounce_lap", 32'(lap_freeze), 32'd0);

    expQ.push_back(EV_SHORT2);
    applyStimulus(3'b100, 3);
    checkOutput("ch2_running", 32'(running), 32'd1);
    checkOutput("ch2_lap", 32'(lap_freeze), 32'd0);

    // Reset in the middle of a ch0 press that is held throughout
    button = 3'b001;
    waitCycles(3 * DIV);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst_clear", 32'(clear), 32'd1);
    checkOutput("midrst_running", 32'(running), 32'd0);
    checkOutput("midrst_short", 32'(short_evt), 32'd0);
    waitCycles(2);
    rst = 1'b0;
    #1;
    checkOutput("midrst_clear_after", 32'(clear), 32'd1);
    waitCycles(1);
    checkOutput("midrst_idle_clear", 32'(clear), 32'd0);
    checkOutput("midrst_idle_running", 32'(running), 32'd0);
    waitCycles(4 * DIV);
    expQ.push_back(EV_SHORT0);
    expQ.push_back(EV_PREP);
    button = '0;
    waitCycles(8 * DIV);
    checkOutput("midrst_run", 32'(running), 32'd1);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
